reaction_game_ctrl: RTL and testbench
=====================================

REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_MS, default 50000: clk cycles per millisecond tick.
REQ-002 SHALL have parameter PHASE_MS, default 1000: duration of each countdown digit, in ms.
REQ-003 SHALL have parameter WAIT_STEP_MS, default 64: ms per unit of random hold.
REQ-004 SHALL have parameter MAX_MS, default 9999: reaction-count saturation / timeout value.
REQ-005 SHALL have port clk, input, 1: system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: synchronous, level-sampled start request.
REQ-008 SHALL have port btn, input, 1: asynchronous player button, active-high.
REQ-009 SHALL have port state, output, 3: FSM state, encoded IDLE=0, COUNT=1, WAIT=2, GO=3, DONE=4, DQ=5, TMO=6.
REQ-010 SHALL have port digit, output, 2: countdown digit 3/2/1 in COUNT, 0 otherwise.
REQ-011 SHALL have port go_led, output, 1: high only in GO.
REQ-012 SHALL have port result_ms, output, 14: latched reaction time in ms.
REQ-013 SHALL have port result_valid, output, 1: one-cycle pulse when result_ms is updated.

Function
REQ-014 SHALL synchronize btn through two flops and derive press as the rising edge of the synchronized signal; press is visible to the FSM 3 cycles after btn is first sampled high.
REQ-015 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle, seed 16'hACE1, and never holds all-zero.
REQ-016 SHALL generate ms_tick: a divider counting 0..CLK_PER_MS-1, pulsing on terminal count; the divider is cleared on every state transition.
REQ-017 IDLE: start=1 -> COUNT with digit=3; snapshot R = LFSR[3:0].
REQ-018 COUNT: after PHASE_MS ticks, digit decrements 3->2->1; after PHASE_MS ticks at digit 1 -> WAIT.
REQ-019 WAIT: lasts R*WAIT_STEP_MS ticks, then -> GO with ms counter = 0; when R=0, WAIT lasts exactly 1 cycle.
REQ-020 press in COUNT or WAIT (including the final WAIT cycle) -> DQ; result_ms is unchanged and result_valid stays 0.
REQ-021 GO: the ms counter increments per ms_tick; press -> DONE, result_ms = counter value before any same-cycle increment, result_valid = 1 for one cycle.
REQ-022 GO: when the counter reaches MAX_MS without a press -> TMO, result_ms = MAX_MS, result_valid pulses.
REQ-023 DONE/DQ/TMO: hold outputs; start=1 -> COUNT (new R snapshot); press is ignored.
REQ-024 start SHALL be ignored in COUNT, WAIT and GO; press SHALL be ignored in IDLE.
REQ-025 When start and press coincide in IDLE/DONE/DQ/TMO, start wins and press is discarded.
REQ-026 A btn held high across the start transition SHALL NOT create a press; only a new rising edge counts.

Reset
REQ-027 reset SHALL force state=IDLE, digit=0, go_led=0, result_ms=0, result_valid=0, divider=0, ms counter=0, sync flops=0, LFSR=16'hACE1.
REQ-028 reset asserted in any state, mid-phase, SHALL take effect on the next edge and override start and press.

Verification
(CLK_PER_MS=4, PHASE_MS=2, WAIT_STEP_MS=1, MAX_MS=20)
REQ-029 Nominal run: start, LFSR forced so R=3, press 10 ms after go_led rises -> digit 3,2,1 each 8 cycles, WAIT 12 cycles, DONE, result_ms=10, one result_valid pulse.
REQ-030 Early press: press during digit=2 -> state=DQ next cycle, result_ms keeps its prior value, no result_valid; then start -> COUNT.
REQ-031 No press: remain in GO -> TMO after 80 cycles, result_ms=20, one result_valid pulse.
REQ-032 Boundary: press edge coincides with an ms_tick in GO at counter=5 -> result_ms=5; press in the last WAIT cycle -> DQ.
REQ-033 Reset mid-GO at counter=7 -> IDLE next edge, all outputs at reset values; btn held through the next start produces no press until released and re-pressed.

Source files
------------

// File: rtl/reaction_game_ctrl.sv
// rtl/reaction_game_ctrl.sv - reaction-time game sequencer
//
// Sequences a reaction-time game: a 3-2-1 countdown, then a pseudo-random hold,
// then GO, after which the player's reaction is timed in milliseconds.
//
// Parameters
//   CLK_PER_MS   clk cycles per millisecond tick
//   PHASE_MS     length of each countdown digit, in ms
//   WAIT_STEP_MS ms per unit of the random hold (hold = R * WAIT_STEP_MS)
//   MAX_MS       reaction-count saturation / timeout value
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        level-sampled start request
//   btn          asynchronous player button, active-high
//   state        IDLE=0 COUNT=1 WAIT=2 GO=3 DONE=4 DQ=5 TMO=6
//   digit        countdown digit (3/2/1) in COUNT, 0 otherwise
//   go_led       high only in GO
//   result_ms    latched reaction time in ms
//   result_valid one-cycle pulse when result_ms is updated
module reaction_game_ctrl #(
    parameter int CLK_PER_MS   = 50000,
    parameter int PHASE_MS     = 1000,
    parameter int WAIT_STEP_MS = 64,
    parameter int MAX_MS       = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        btn,
    output logic [2:0]  state,
    output logic [1:0]  digit,
    output logic        go_led,
    output logic [13:0] result_ms,
    output logic        result_valid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_WAIT  = 3'd2,
        S_GO    = 3'd3,
        S_DONE  = 3'd4,
        S_DQ    = 3'd5,
        S_TMO   = 3'd6
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int DIV_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_MS - 1);
    localparam logic [15:0] PHASE_LAST = 16'(PHASE_MS - 1);
    localparam logic [13:0] MS_MAX     = 14'(MAX_MS);
    localparam logic [13:0] MS_LAST    = 14'(MAX_MS - 1);

    // ------------------------------------------------------------------
    // Button synchronizer and rising-edge detector. press_q is registered
    // so the FSM sees it three edges after btn is first sampled high.
    // ------------------------------------------------------------------
    logic btn_s1_q, btn_s2_q, btn_prev_q, press_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            btn_s1_q   <= btn;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            press_q    <= btn_s2_q & ~btn_prev_q;
        end
    end

    // ------------------------------------------------------------------
    // Free-running LFSR, taps 16,14,13,11. The all-zero guard reloads the
    // seed so the generator can never lock up.
    // ------------------------------------------------------------------
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
        if (lfsr_q == 16'h0000) begin
            lfsr_d = LFSR_SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM with its divider, phase counter and ms counter. The divider is
    // owned here because every state change restarts it from zero.
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [1:0]         digit_q;
    logic               go_led_q;
    logic [13:0]        result_ms_q;
    logic               result_valid_q;
    logic [DIV_W-1:0]   div_q;
    logic [15:0]        tcnt_q;      // ms ticks elapsed in the current digit / hold
    logic [13:0]        ms_q;        // reaction counter in GO
    logic [3:0]         r_q;         // random hold multiplier snapshot
    logic               ms_tick;
    logic [31:0]        wait_prod;
    logic [15:0]        wait_last;

    assign ms_tick   = (div_q == DIV_LAST);
    assign wait_prod = 32'(r_q) * 32'(WAIT_STEP_MS);
    assign wait_last = 16'(wait_prod - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            digit_q        <= 2'd0;
            go_led_q       <= 1'b0;
            result_ms_q    <= 14'd0;
            result_valid_q <= 1'b0;
            div_q          <= '0;
            tcnt_q         <= 16'd0;
            ms_q           <= 14'd0;
            r_q            <= 4'd0;
        end else begin
            result_valid_q <= 1'b0;
            div_q          <= ms_tick ? '0 : div_q + DIV_W'(1);

            case (state_q)
                S_IDLE, S_DONE, S_DQ, S_TMO: begin
                    // start beats a coincident press; press alone is ignored here
                    if (start) begin
                        state_q <= S_COUNT;
                        digit_q <= 2'd3;
                        tcnt_q  <= 16'd0;
                        div_q   <= '0;
                        r_q     <= lfsr_q[3:0];
                    end
                end

                S_COUNT: begin
                    if (press_q) begin
                        state_q <= S_DQ;
                        digit_q <= 2'd0;
                        div_q   <= '0;
                    end else if (ms_tick) begin
                        if (tcnt_q == PHASE_LAST) begin
                            tcnt_q <= 16'd0;
                            if (digit_q == 2'd1) begin
                                state_q <= S_WAIT;
                                digit_q <= 2'd0;
                                div_q   <= '0;
                            end else begin
                                digit_q <= digit_q - 2'd1;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + 16'd1;
                        end
                    end
                end

                S_WAIT: begin
                    // A zero hold still spends one cycle here, during which
                    // a press disqualifies.
                    if (press_q) begin
                        state_q <= S_DQ;
                        div_q   <= '0;
                    end else if ((r_q == 4'd0) || (ms_tick && (tcnt_q == wait_last))) begin
                        state_q  <= S_GO;
                        go_led_q <= 1'b1;
                        ms_q     <= 14'd0;
                        tcnt_q   <= 16'd0;
                        div_q    <= '0;
                    end else if (ms_tick) begin
                        tcnt_q <= tcnt_q + 16'd1;
                    end
                end

                S_GO: begin
                    // Press reports the count before any same-cycle tick.
                    if (press_q) begin
                        state_q        <= S_DONE;
                        go_led_q       <= 1'b0;
                        result_ms_q    <= ms_q;
                        result_valid_q <= 1'b1;
                        div_q          <= '0;
                    end else if (ms_tick) begin
                        if (ms_q == MS_LAST) begin
                            state_q        <= S_TMO;
                            go_led_q       <= 1'b0;
                            ms_q           <= MS_MAX;
                            result_ms_q    <= MS_MAX;
                            result_valid_q <= 1'b1;
                            div_q          <= '0;
                        end else begin
                            ms_q <= ms_q + 14'd1;
                        end
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    digit_q  <= 2'd0;
                    go_led_q <= 1'b0;
                    div_q    <= '0;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign digit        = digit_q;
    assign go_led       = go_led_q;
    assign result_ms    = result_ms_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// tb/tb_reaction_game_ctrl.sv - self-checking bench for reaction_game_ctrl
module tb_reaction_game_ctrl;

    localparam int CLK_PER_MS   = 4;
    localparam int PHASE_MS     = 2;
    localparam int WAIT_STEP_MS = 1;
    localparam int MAX_MS       = 20;
    localparam int PC           = CLK_PER_MS * PHASE_MS;

    localparam int S_IDLE = 0, S_COUNT = 1, S_WAIT = 2, S_GO = 3;
    localparam int S_DONE = 4, S_DQ = 5, S_TMO = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        btn = 1'b0;
    logic [2:0]  state;
    logic [1:0]  digit;
    logic        go_led;
    logic [13:0] result_ms;
    logic        result_valid;

    reaction_game_ctrl #(
        .CLK_PER_MS  (CLK_PER_MS),
        .PHASE_MS    (PHASE_MS),
        .WAIT_STEP_MS(WAIT_STEP_MS),
        .MAX_MS      (MAX_MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .btn         (btn),
        .state       (state),
        .digit       (digit),
        .go_led      (go_led),
        .result_ms   (result_ms),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_valid = 0;

    // Reference model: state plus cycles spent in it; everything else is
    // derived from elapsed time with plain arithmetic.
    int          m_state = S_IDLE;
    int          m_el    = 0;
    int          m_R     = 0;
    int          m_res   = 0;
    int          m_valid = 0;
    logic [15:0] m_lfsr  = 16'hACE1;
    logic [4:1]  hist    = 4'b0000;   // btn samples from 1..4 edges ago

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        int   taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        if (x == 16'h0000) return 16'hACE1;
        foreach (taps[i]) fb ^= x[taps[i]-1];
        return {x[14:0], fb};
    endfunction

    function automatic int m_digit();
        if (m_state == S_COUNT) return 3 - m_el / PC;
        return 0;
    endfunction

    function automatic int wait_len();
        int wl = m_R * WAIT_STEP_MS * CLK_PER_MS;
        return (wl == 0) ? 1 : wl;
    endfunction

    task automatic enter_count();
        m_state = S_COUNT;
        m_el    = 0;
        m_R     = int'(m_lfsr[3:0]);
    endtask

    task automatic model_step();
        logic press;
        if (reset) begin
            m_state = S_IDLE; m_el = 0; m_res = 0; m_valid = 0; m_R = 0;
            m_lfsr  = 16'hACE1;
            hist    = 4'b0000;
        end else begin
            press   = hist[3] & ~hist[4];
            hist    = {hist[3:1], btn};
            m_valid = 0;
            case (m_state)
                S_IDLE, S_DONE, S_DQ, S_TMO: if (start) enter_count();
                S_COUNT: begin
                    if (press) begin m_state = S_DQ; m_el = 0; end
                    else if (m_el + 1 == 3 * PC) begin m_state = S_WAIT; m_el = 0; end
                    else m_el++;
                end
                S_WAIT: begin
                    if (press) begin m_state = S_DQ; m_el = 0; end
                    else if (m_el + 1 == wait_len()) begin m_state = S_GO; m_el = 0; end
                    else m_el++;
                end
                S_GO: begin
                    if (press) begin
                        m_state = S_DONE; m_res = m_el / CLK_PER_MS; m_valid = 1; m_el = 0;
                    end else if (m_el + 1 == MAX_MS * CLK_PER_MS) begin
                        m_state = S_TMO; m_res = MAX_MS; m_valid = 1; m_el = 0;
                    end else m_el++;
                end
                default: m_state = S_IDLE;
            endcase
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("state", 32'(state), m_state);
        chk("digit", 32'(digit), m_digit());
        chk("go_led", 32'(go_led), (m_state == S_GO) ? 1 : 0);
        chk("result_ms", 32'(result_ms), m_res);
        chk("result_valid", 32'(result_valid), m_valid);
        if (result_valid === 1'b1) n_valid++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_model(input int st, input int el, input int budget);
        int n = 0;
        while (!(m_state == st && m_el == el) && n < budget) begin
            tick();
            n++;
        end
        chk("reach_state", 32'(state), st);
    endtask

    task automatic count_while_state(input int st, input int budget, output int cnt);
        cnt = 0;
        while (int'(state) == st && cnt < budget) begin
            cnt++;
            tick();
        end
    endtask

    task automatic count_while_digit(input int d, output int cnt);
        cnt = 0;
        while (int'(digit) == d && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        int cnt;
        int n;
        int rate;

        // reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_state", 32'(state), S_IDLE);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_go", 32'(go_led), 0);
        chk("rst_result", 32'(result_ms), 0);

        // nominal run with R=3
        n = 0;
        while (m_lfsr[3:0] != 4'd3 && n < 200) begin tick(); n++; end
        pulse_start();
        chk("nom_r", m_R, 3);
        count_while_digit(3, cnt); chk("nom_d3_len", cnt, 8);
        count_while_digit(2, cnt); chk("nom_d2_len", cnt, 8);
        count_while_digit(1, cnt); chk("nom_d1_len", cnt, 0 + 8);
        count_while_state(S_WAIT, 100, cnt); chk("nom_wait_len", cnt, 12);
        chk("nom_go_led", 32'(go_led), 1);
        n_valid = 0;
        run_to_model(S_GO, 37, 200);
        btn = 1'b1;
        count_while_state(S_GO, 20, cnt);
        chk("nom_done", 32'(state), S_DONE);
        chk("nom_result", 32'(result_ms), 10);
        repeat (3) tick();
        chk("nom_pulses", n_valid, 1);
        btn = 1'b0;
        repeat (4) tick();

        // early press during digit 2
        pulse_start();
        n_valid = 0;
        n = 0;
        while (digit != 2'd2 && n < 100) begin tick(); n++; end
        btn = 1'b1;
        count_while_state(S_COUNT, 10, cnt);
        chk("early_dq", 32'(state), S_DQ);
        chk("early_result", 32'(result_ms), 10);
        chk("early_no_valid", n_valid, 0);
        btn = 1'b0;
        repeat (4) tick();
        pulse_start();
        chk("dq_restart", 32'(state), S_COUNT);

        // no press: timeout
        n = 0;
        while (int'(state) != S_GO && n < 300) begin tick(); n++; end
        n_valid = 0;
        count_while_state(S_GO, 200, cnt);
        chk("tmo_len", cnt, 80);
        chk("tmo_state", 32'(state), S_TMO);
        chk("tmo_result", 32'(result_ms), 20);
        repeat (3) tick();
        chk("tmo_pulses", n_valid, 1);

        // press coincides with the tick at counter 5
        pulse_start();
        run_to_model(S_GO, 20, 300);
        btn = 1'b1;
        count_while_state(S_GO, 20, cnt);
        chk("tick_press_state", 32'(state), S_DONE);
        chk("tick_press_result", 32'(result_ms), 5);
        btn = 1'b0;
        repeat (4) tick();

        // press in the last WAIT cycle
        n = 0;
        while (m_lfsr[3:0] == 4'd0 && n < 50) begin tick(); n++; end
        pulse_start();
        run_to_model(S_WAIT, wait_len() - 4, 300);
        btn = 1'b1;
        count_while_state(S_WAIT, 20, cnt);
        chk("last_wait_dq", 32'(state), S_DQ);
        btn = 1'b0;
        repeat (4) tick();

        // reset mid-GO at counter 7, then btn held across start
        pulse_start();
        run_to_model(S_GO, 28, 300);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rgo_state", 32'(state), S_IDLE);
        chk("rgo_digit", 32'(digit), 0);
        chk("rgo_go", 32'(go_led), 0);
        chk("rgo_result", 32'(result_ms), 0);
        chk("rgo_valid", 32'(result_valid), 0);
        btn = 1'b1;
        repeat (5) tick();
        pulse_start();
        n = 0;
        while (int'(state) != S_GO && n < 300) begin tick(); n++; end
        chk("held_reaches_go", 32'(state), S_GO);
        repeat (5) tick();
        btn = 1'b0;
        repeat (3) tick();
        btn = 1'b1;
        count_while_state(S_GO, 20, cnt);
        chk("repress_done", 32'(state), S_DONE);
        btn = 1'b0;
        repeat (4) tick();

        // randomized traffic against the model
        for (int seg = 0; seg < 12; seg++) begin
            rate = int'($urandom_range(4, 120));
            for (int i = 0; i < 250; i++) begin
                start = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, rate) == 0) btn = ~btn;
                reset = ($urandom_range(0, 599) == 0);
                tick();
            end
        end
        start = 1'b0;
        reset = 1'b0;
        btn   = 1'b0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
